// File: rtl/wolverine_mc_pkg.sv
// Shared definitions for the Wolverine memory-controller arbiter.
//   - MC port field widths
//   - MC request/response command encodings
//   - flush sequencer state type (flush_state_t)
package wolverine_mc_pkg;

    localparam int MC_ADDR_W   = 48;
    localparam int MC_DATA_W   = 64;
    localparam int MC_RTNCTL_W = 32;
    localparam int MC_SIZE_W   = 2;
    localparam int MC_CMD_W    = 3;
    localparam int MC_SCMD_W   = 4;

    // Request commands
    localparam logic [MC_CMD_W-1:0] MC_CMD_IDLE = 3'd0;
    localparam logic [MC_CMD_W-1:0] MC_CMD_RD   = 3'd1;
    localparam logic [MC_CMD_W-1:0] MC_CMD_WR   = 3'd2;
    localparam logic [MC_CMD_W-1:0] MC_CMD_ATOM = 3'd3;

    // Response commands
    localparam logic [MC_CMD_W-1:0] MC_RSP_RD_DATA = 3'd2;
    localparam logic [MC_CMD_W-1:0] MC_RSP_WR_CMP  = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } flush_state_t;

endpackage

// File: rtl/wolverine_rr_arbiter.sv
// Round-robin picker over NREQ request lines.
//   clock, reset_n : clock, synchronous active-low reset
//   en             : a grant is taken this cycle; advance pointer past winner
//   req            : request lines
//   grant          : one-hot winner (first set bit at or after the pointer)
//   grant_id       : binary index of the winner
//   any            : some request line is set
module wolverine_rr_arbiter
    import wolverine_mc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [IDW-1:0] ptr;

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (en && any) begin
            ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: rtl/wolverine_mc_arbiter.sv
// Shares one Wolverine MC port among NREQ requesters.
//   req_*      : per-requester request beats, accepted when req_valid & !req_stall
//   res_*      : responses routed back by the ID stamped in RtnCtl[31:32-IDW]
//   flush_req / flush_ok : per-requester flush level request / done pulse
//   mc_req_* / mc_res_* / mc_req_flush / mc_res_flush_ok : downstream MC port
//   dbg_state  : flush sequencer state
// Handshake: a request beat transfers when valid is high and stall is low in
// the same cycle; mc_req_valid is a one-cycle registered pulse that the MC must
// absorb even when it raises mc_req_stall (it guarantees one cycle of slack).
// Optional: `define WOLV_MC_ARB_PERF_EN adds perf_sel/perf_data counters.
module wolverine_mc_arbiter
    import wolverine_mc_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ),
    parameter int RTW    = 32 - IDW,
    parameter int MAXOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*RTW-1:0]       req_rtnctl,
    input  logic [NREQ*MC_DATA_W-1:0] req_data,
    input  logic [NREQ*MC_ADDR_W-1:0] req_addr,
    input  logic [NREQ*MC_SIZE_W-1:0] req_size,
    input  logic [NREQ*MC_CMD_W-1:0]  req_cmd,
    input  logic [NREQ*MC_SCMD_W-1:0] req_scmd,
    output logic [NREQ-1:0]           req_stall,
    output logic [NREQ-1:0]           res_valid,
    output logic [MC_CMD_W-1:0]       res_cmd,
    output logic [MC_SCMD_W-1:0]      res_scmd,
    output logic [MC_DATA_W-1:0]      res_data,
    output logic [RTW-1:0]            res_rtnctl,
    input  logic [NREQ-1:0]           res_stall,
    input  logic [NREQ-1:0]           flush_req,
    output logic [NREQ-1:0]           flush_ok,
    output logic                      mc_req_valid,
    output logic [MC_RTNCTL_W-1:0]    mc_req_rtnctl,
    output logic [MC_DATA_W-1:0]      mc_req_data,
    output logic [MC_ADDR_W-1:0]      mc_req_addr,
    output logic [MC_SIZE_W-1:0]      mc_req_size,
    output logic [MC_CMD_W-1:0]       mc_req_cmd,
    output logic [MC_SCMD_W-1:0]      mc_req_scmd,
    input  logic                      mc_req_stall,
    input  logic                      mc_res_valid,
    input  logic [MC_CMD_W-1:0]       mc_res_cmd,
    input  logic [MC_SCMD_W-1:0]      mc_res_scmd,
    input  logic [MC_DATA_W-1:0]      mc_res_data,
    input  logic [MC_RTNCTL_W-1:0]    mc_res_rtnctl,
    output logic                      mc_res_stall,
    output logic                      mc_req_flush,
    input  logic                      mc_res_flush_ok,
`ifdef WOLV_MC_ARB_PERF_EN
    input  logic [$clog2(NREQ):0]     perf_sel,
    output logic [31:0]               perf_data,
`endif
    output flush_state_t              dbg_state
);

    localparam int OCW = $clog2(MAXOUT) + 1;

    flush_state_t    state;
    logic [NREQ-1:0] mask;
    logic [OCW-1:0]  outstanding;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_id;
    logic            win_any;
    logic            grant;
    logic            res_fire;
    logic [IDW-1:0]  res_id;

    logic [RTW-1:0]       sel_rtnctl;
    logic [MC_DATA_W-1:0] sel_data;
    logic [MC_ADDR_W-1:0] sel_addr;
    logic [MC_SIZE_W-1:0] sel_size;
    logic [MC_CMD_W-1:0]  sel_cmd;
    logic [MC_SCMD_W-1:0] sel_scmd;

    // A raised flush_req blocks grants already in the IDLE cycle that sees it,
    // and reset_n keeps req_stall all-ones while reset is held.
    assign grant = reset_n && (state == IDLE) && !(|flush_req) && !mc_req_stall
                   && (outstanding < OCW'(MAXOUT)) && win_any;

    assign req_stall = grant ? ~win_oh : '1;
    assign dbg_state = state;

    wolverine_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (grant),
        .req      (req_valid),
        .grant    (win_oh),
        .grant_id (win_id),
        .any      (win_any)
    );

    always_comb begin
        sel_rtnctl = '0;
        sel_data   = '0;
        sel_addr   = '0;
        sel_size   = '0;
        sel_cmd    = '0;
        sel_scmd   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_rtnctl = req_rtnctl[i*RTW +: RTW];
                sel_data   = req_data[i*MC_DATA_W +: MC_DATA_W];
                sel_addr   = req_addr[i*MC_ADDR_W +: MC_ADDR_W];
                sel_size   = req_size[i*MC_SIZE_W +: MC_SIZE_W];
                sel_cmd    = req_cmd[i*MC_CMD_W +: MC_CMD_W];
                sel_scmd   = req_scmd[i*MC_SCMD_W +: MC_SCMD_W];
            end
        end
    end

    // The registered beat is always presented; mc_req_stall only gates grants.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mc_req_valid  <= 1'b0;
            mc_req_rtnctl <= '0;
            mc_req_data   <= '0;
            mc_req_addr   <= '0;
            mc_req_size   <= '0;
            mc_req_cmd    <= '0;
            mc_req_scmd   <= '0;
        end else begin
            mc_req_valid <= grant;
            if (grant) begin
                mc_req_rtnctl <= {win_id, sel_rtnctl};
                mc_req_data   <= sel_data;
                mc_req_addr   <= sel_addr;
                mc_req_size   <= sel_size;
                mc_req_cmd    <= sel_cmd;
                mc_req_scmd   <= sel_scmd;
            end
        end
    end

    // Response routing; IDs with no matching requester light no res_valid
    // and see no stall, so the beat is consumed and dropped.
    assign res_id     = mc_res_rtnctl[MC_RTNCTL_W-1 -: IDW];
    assign res_rtnctl = mc_res_rtnctl[RTW-1:0];
    assign res_cmd    = mc_res_cmd;
    assign res_scmd   = mc_res_scmd;
    assign res_data   = mc_res_data;

    always_comb begin
        res_valid    = '0;
        mc_res_stall = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (res_id == IDW'(i)) begin
                res_valid[i] = mc_res_valid;
                mc_res_stall = res_stall[i];
            end
        end
    end

    assign res_fire = mc_res_valid && !mc_res_stall;

    // Saturates at zero so a stray response after reset is not counted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (grant && !res_fire) begin
            outstanding <= outstanding + OCW'(1);
        end else if (!grant && res_fire && (outstanding != '0)) begin
            outstanding <= outstanding - OCW'(1);
        end
    end

    // Flush sequencer
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            mask         <= '0;
            mc_req_flush <= 1'b0;
            flush_ok     <= '0;
        end else begin
            flush_ok <= '0;
            case (state)
                IDLE: begin
                    if (|flush_req) begin
                        mask  <= flush_req;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mask <= mask | flush_req;
                    if (!mc_req_valid && (outstanding == '0)) begin
                        state        <= FLUSH;
                        mc_req_flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (mc_res_flush_ok) begin
                        state        <= DONE;
                        mc_req_flush <= 1'b0;
                        flush_ok     <= mask;
                    end
                end
                DONE: begin
                    mask  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WOLV_MC_ARB_PERF_EN
    localparam int PSW = $clog2(NREQ) + 1;

    logic [31:0] grant_cnt [NREQ];
    logic [31:0] stall_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
            perf_data <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant && win_oh[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
            end
            if (mc_req_stall && |req_valid) stall_cnt <= stall_cnt + 32'd1;
            perf_data <= '0;
            if (perf_sel == PSW'(NREQ)) perf_data <= stall_cnt;
            for (int i = 0; i < NREQ; i++) begin
                if (perf_sel == PSW'(i)) perf_data <= grant_cnt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wolverine_mc_arbiter.sv
module tb_wolverine_mc_arbiter;
    import wolverine_mc_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int RTW  = 30;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*RTW-1:0]  req_rtnctl;
    logic [NREQ*64-1:0]   req_data;
    logic [NREQ*48-1:0]   req_addr;
    logic [NREQ*2-1:0]    req_size;
    logic [NREQ*3-1:0]    req_cmd;
    logic [NREQ*4-1:0]    req_scmd;
    logic [NREQ-1:0]      req_stall;
    logic [NREQ-1:0]      res_valid;
    logic [2:0]           res_cmd;
    logic [3:0]           res_scmd;
    logic [63:0]          res_data;
    logic [RTW-1:0]       res_rtnctl;
    logic [NREQ-1:0]      res_stall;
    logic [NREQ-1:0]      flush_req;
    logic [NREQ-1:0]      flush_ok;
    logic                 mc_req_valid;
    logic [31:0]          mc_req_rtnctl;
    logic [63:0]          mc_req_data;
    logic [47:0]          mc_req_addr;
    logic [1:0]           mc_req_size;
    logic [2:0]           mc_req_cmd;
    logic [3:0]           mc_req_scmd;
    logic                 mc_req_stall;
    logic                 mc_res_valid;
    logic [2:0]           mc_res_cmd;
    logic [3:0]           mc_res_scmd;
    logic [63:0]          mc_res_data;
    logic [31:0]          mc_res_rtnctl;
    logic                 mc_res_stall;
    logic                 mc_req_flush;
    logic                 mc_res_flush_ok;
    flush_state_t         dbg_state;
`ifdef WOLV_MC_ARB_PERF_EN
    logic [2:0]           perf_sel;
    logic [31:0]          perf_data;
`endif

    wolverine_mc_arbiter #(.NREQ(NREQ), .MAXOUT(64)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_rtnctl      (req_rtnctl),
        .req_data        (req_data),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_cmd         (req_cmd),
        .req_scmd        (req_scmd),
        .req_stall       (req_stall),
        .res_valid       (res_valid),
        .res_cmd         (res_cmd),
        .res_scmd        (res_scmd),
        .res_data        (res_data),
        .res_rtnctl      (res_rtnctl),
        .res_stall       (res_stall),
        .flush_req       (flush_req),
        .flush_ok        (flush_ok),
        .mc_req_valid    (mc_req_valid),
        .mc_req_rtnctl   (mc_req_rtnctl),
        .mc_req_data     (mc_req_data),
        .mc_req_addr     (mc_req_addr),
        .mc_req_size     (mc_req_size),
        .mc_req_cmd      (mc_req_cmd),
        .mc_req_scmd     (mc_req_scmd),
        .mc_req_stall    (mc_req_stall),
        .mc_res_valid    (mc_res_valid),
        .mc_res_cmd      (mc_res_cmd),
        .mc_res_scmd     (mc_res_scmd),
        .mc_res_data     (mc_res_data),
        .mc_res_rtnctl   (mc_res_rtnctl),
        .mc_res_stall    (mc_res_stall),
        .mc_req_flush    (mc_req_flush),
        .mc_res_flush_ok (mc_res_flush_ok),
`ifdef WOLV_MC_ARB_PERF_EN
        .perf_sel        (perf_sel),
        .perf_data       (perf_data),
`endif
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [31:0] rtn;
        logic [3:0]  rs;
        logic [3:0]  e_valid;
        logic [29:0] e_rtn;
        logic        e_stall;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid       = '0;
        req_rtnctl      = '0;
        req_data        = '0;
        req_addr        = '0;
        req_size        = '0;
        req_cmd         = '0;
        req_scmd        = '0;
        res_stall       = '0;
        flush_req       = '0;
        mc_req_stall    = 1'b0;
        mc_res_valid    = 1'b0;
        mc_res_cmd      = '0;
        mc_res_scmd     = '0;
        mc_res_data     = '0;
        mc_res_rtnctl   = '0;
        mc_res_flush_ok = 1'b0;
`ifdef WOLV_MC_ARB_PERF_EN
        perf_sel        = '0;
`endif
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [29:0] rtn, input logic [47:0] addr,
                           input logic [63:0] data);
        req_rtnctl[i*RTW +: RTW] = rtn;
        req_addr[i*48 +: 48]     = addr;
        req_data[i*64 +: 64]     = data;
        req_cmd[i*3 +: 3]        = MC_CMD_RD;
        req_size[i*2 +: 2]       = 2'd3;
    endtask

    task automatic set_res(input logic v, input logic [31:0] rtn);
        mc_res_valid  = v;
        mc_res_rtnctl = rtn;
        mc_res_cmd    = MC_RSP_RD_DATA;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    // ---------------- test ----------------
    initial begin
        logic [3:0] e_stall;
        int         beats;

        vecs[0] = '{1'b1, 32'hC000_0007, 4'b0000, 4'b1000, 30'h7,         1'b0};
        vecs[1] = '{1'b1, 32'h4000_0001, 4'b0000, 4'b0010, 30'h1,         1'b0};
        vecs[2] = '{1'b1, 32'hC000_0007, 4'b1000, 4'b1000, 30'h7,         1'b1};
        vecs[3] = '{1'b0, 32'h8000_0003, 4'b0100, 4'b0000, 30'h3,         1'b1};
        vecs[4] = '{1'b1, 32'h3FFF_FFFF, 4'b1110, 4'b0001, 30'h3FFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, 32'h8000_0000, 4'b0000, 4'b0100, 30'h0,         1'b0};

        // Reset values, with requesters already asserting valid.
        reset_n = 1'b0;
        clear_inputs();
        req_valid = 4'b1111;
        repeat (2) @(posedge clock);
        #2;
        check("rst_mc_req_valid", mc_req_valid, 0);
        check("rst_req_stall", req_stall, 4'b1111);
        check("rst_res_valid", res_valid, 0);
        check("rst_flush_ok", flush_ok, 0);
        check("rst_mc_req_flush", mc_req_flush, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_outstanding", dut.outstanding, 0);
        do_reset();

        // Requester 0: four back-to-back reads, rtnctl=5.
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4) ? 4'b0001 : 4'b0000;
            set_req(0, 30'd5, 48'(k * 64), 64'(k + 100));
            #1;
            check("t1_req_stall", req_stall, (k < 4) ? 4'b1110 : 4'b1111);
            check("t1_mc_req_valid", mc_req_valid, (k >= 1 && k <= 4) ? 1 : 0);
            if (k >= 1 && k <= 4) begin
                check("t1_rtnctl", mc_req_rtnctl, 32'h0000_0005);
                check("t1_addr", mc_req_addr, 48'((k - 1) * 64));
                check("t1_data", mc_req_data, 64'(k - 1 + 100));
                check("t1_cmd", mc_req_cmd, MC_CMD_RD);
            end
            next_cycle();
        end
        check("t1_outstanding", dut.outstanding, 4);

        // All four valid: round-robin 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 30'(32'h100 + i), 48'(i), 64'(i));
        for (int g = 0; g < 8; g++) exp_q.push_back({2'(g % 4), 30'(32'h100 + g % 4)});
        beats = 0;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            e_stall = ~(4'b0001 << (k % 4));
            if (k < 8) check("t2_req_stall", req_stall, e_stall);
            if (k == 3) check("t2_id2", mc_req_rtnctl[31:30], 2);
            if (mc_req_valid) begin
                beats++;
                if (exp_q.size() == 0) check("t2_extra_beat", 1, 0);
                else check("t2_rtnctl", mc_req_rtnctl, exp_q.pop_front());
            end
            next_cycle();
        end
        check("t2_beats", beats, 8);
        check("t2_queue_empty", exp_q.size(), 0);

        // Downstream stall: one registered beat leaves, then none.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 14; k++) begin
            mc_req_stall = (k >= 1 && k <= 10);
            #1;
            if (k == 0) e_stall = 4'b1110;
            else if (k >= 11) e_stall = ~(4'b0001 << (k - 10));
            else e_stall = 4'b1111;
            check("t3_req_stall", req_stall, e_stall);
            check("t3_mc_req_valid", mc_req_valid, (k == 1 || k >= 12) ? 1 : 0);
            next_cycle();
        end
        req_valid    = '0;
        mc_req_stall = 1'b0;

        // Response routing table (stray responses after reset).
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_res(vecs[i].v, vecs[i].rtn);
            res_stall   = vecs[i].rs;
            mc_res_data = 64'hDEAD_0000 + 64'(i);
            #1;
            check("t4_res_valid", res_valid, vecs[i].e_valid);
            check("t4_res_rtnctl", res_rtnctl, vecs[i].e_rtn);
            check("t4_mc_res_stall", mc_res_stall, vecs[i].e_stall);
            check("t4_res_data", res_data, 64'hDEAD_0000 + 64'(i));
            check("t4_res_cmd", res_cmd, MC_RSP_RD_DATA);
            next_cycle();
        end
        set_res(1'b0, 32'h0);
        res_stall = '0;
        check("t4_stray_not_counted", dut.outstanding, 0);

        // Counter holds while the response is stalled.
        req_valid = 4'b0001;
        #1;
        next_cycle();
        req_valid = '0;
        set_res(1'b1, 32'hC000_0007);
        res_stall = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_hold_stall", mc_res_stall, 1);
            check("t4_hold_count", dut.outstanding, 1);
            next_cycle();
        end
        res_stall = '0;
        #1;
        next_cycle();
        set_res(1'b0, 32'h0);
        #1;
        check("t4_count_after", dut.outstanding, 0);

        // MAXOUT reached with no responses.
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 64; k++) begin
            #1;
            check("t5_fill_stall", req_stall, 4'b1110);
            next_cycle();
        end
        #1;
        check("t5_full_stall", req_stall, 4'b1111);
        check("t5_full_count", dut.outstanding, 64);
        next_cycle();
        set_res(1'b1, 32'h0);
        #1;
        check("t5_resp_cycle_stall", req_stall, 4'b1111);
        next_cycle();
        set_res(1'b0, 32'h0);
        #1;
        check("t5_one_more_grant", req_stall, 4'b1110);
        next_cycle();
        #1;
        check("t5_full_again", req_stall, 4'b1111);
        check("t5_full_again_count", dut.outstanding, 64);
        req_valid = '0;

        // Flush with 3 outstanding.
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6_pre_grant", req_stall, 4'b1110);
            next_cycle();
        end
        for (int k = 3; k < 16; k++) begin
            flush_req       = (k <= 13) ? 4'b0010 : 4'b0000;
            set_res((k >= 5 && k <= 7), 32'h0);
            mc_res_flush_ok = (k == 13);
            #1;
            check("t6_req_stall", req_stall, (k == 15) ? 4'b1110 : 4'b1111);
            check("t6_mc_req_valid", mc_req_valid, (k == 3) ? 1 : 0);
            check("t6_mc_req_flush", mc_req_flush, (k >= 9 && k <= 13) ? 1 : 0);
            check("t6_flush_ok", flush_ok, (k == 14) ? 4'b0010 : 4'b0000);
            if (k == 3 || k == 15) check("t6_state", dbg_state, IDLE);
            else if (k <= 8) check("t6_state", dbg_state, DRAIN);
            else if (k <= 13) check("t6_state", dbg_state, FLUSH);
            else check("t6_state", dbg_state, DONE);
            next_cycle();
        end
        req_valid = '0;
        set_res(1'b0, 32'h0);
        mc_res_flush_ok = 1'b0;

        // Reset in the middle of FLUSH.
        do_reset();
        flush_req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t7_mc_req_flush", mc_req_flush, (k >= 2) ? 1 : 0);
            if (k == 0) check("t7_state", dbg_state, IDLE);
            else if (k == 1) check("t7_state", dbg_state, DRAIN);
            else check("t7_state", dbg_state, FLUSH);
            next_cycle();
        end
        reset_n   = 1'b0;
        flush_req = '0;
        req_valid = 4'b1111;
        #1;
        check("t7_rst_req_stall", req_stall, 4'b1111);
        next_cycle();
        #1;
        check("t7_rst_mc_req_flush", mc_req_flush, 0);
        check("t7_rst_state", dbg_state, IDLE);
        check("t7_rst_flush_ok", flush_ok, 0);
        check("t7_rst_mc_req_valid", mc_req_valid, 0);
        next_cycle();
        reset_n         = 1'b1;
        req_valid       = '0;
        mc_res_flush_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t7_no_flush_ok", flush_ok, 0);
            check("t7_idle", dbg_state, IDLE);
            check("t7_flush_low", mc_req_flush, 0);
            next_cycle();
            mc_res_flush_ok = 1'b0;
        end

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wolverine_mc_arbiter.md
Name: wolverine_mc_arbiter

Overview:
- Shares one Wolverine memory-controller port (mcReq/mcRes/flush) among NREQ requesters inside the AE, as seen by the simulated harness.
- Grants are round-robin; requester ID is stamped into the top bits of RtnCtl, and responses are routed back by that ID.
- Sequences MC flush: drains outstanding traffic, issues one flush, fans flush-OK back to the requesters that asked for it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, ID bits stamped into RtnCtl[31:32-IDW]; IDW = clog2(NREQ).
- RTW, 30, requester RtnCtl width = 32-IDW.
- MAXOUT, 64, maximum outstanding requests (power of 2).

Ports:
- clock in 1: sole clock.
- reset_n in 1: synchronous active-low reset.
- req_valid in NREQ: per-requester request valid.
- req_rtnctl in NREQ*RTW: requester return-control.
- req_data in NREQ*64: store data.
- req_addr in NREQ*48: address.
- req_size in NREQ*2: size.
- req_cmd in NREQ*3: command.
- req_scmd in NREQ*4: subcommand.
- req_stall out NREQ: 0 only in the cycle request i is accepted.
- res_valid out NREQ: one-hot response valid.
- res_cmd out 3: response command, broadcast.
- res_scmd out 4: response subcommand, broadcast.
- res_data out 64: response data, broadcast.
- res_rtnctl out RTW: response RtnCtl with ID stripped, broadcast.
- res_stall in NREQ: per-requester response stall.
- flush_req in NREQ: per-requester flush request (level).
- flush_ok out NREQ: one-cycle flush-done pulse.
- mc_req_valid out 1: downstream request valid.
- mc_req_rtnctl out 32: downstream RtnCtl.
- mc_req_data out 64: downstream data.
- mc_req_addr out 48: downstream address.
- mc_req_size out 2: downstream size.
- mc_req_cmd out 3: downstream command.
- mc_req_scmd out 4: downstream subcommand.
- mc_req_stall in 1: downstream request stall.
- mc_res_valid in 1: downstream response valid.
- mc_res_cmd in 3: downstream response command.
- mc_res_scmd in 4: downstream response subcommand.
- mc_res_data in 64: downstream response data.
- mc_res_rtnctl in 32: downstream response RtnCtl.
- mc_res_stall out 1: stall to downstream response.
- mc_req_flush out 1: downstream flush request.
- mc_res_flush_ok in 1: downstream flush acknowledge.

Behaviour:
- Reset (reset_n=0 at posedge):
  - mc_req_valid, mc_req_flush, res_valid, flush_ok, outstanding count, and flush mask all clear.
  - req_stall = all ones.
  - RR pointer = 0; FSM = IDLE.
- Grant condition (combinational): FSM==IDLE, !mc_req_stall, outstanding < MAXOUT, and some req_valid.
  - Winner is the first valid requester at or after the RR pointer.
  - The winner's req_stall[i] = 0 that cycle; all other req_stall bits = 1.
  - Requester i's beat is consumed when req_valid[i] && !req_stall[i].
- Grant effects:
  - Pointer moves to winner+1 mod NREQ.
  - Request fields are registered. mc_req_valid is asserted exactly one cycle later, for one cycle (latency 1).
  - mc_req_rtnctl = {ID, req_rtnctl}.
  - With no grant, mc_req_valid = 0 the next cycle.
- Downstream stall slack: mc_req_stall gates the grant only. The one beat already registered is always presented, relying on the MC's ≥1-cycle stall slack.
- Outstanding counter, width clog2(MAXOUT)+1:
  - +1 per grant; −1 per mc_res_valid && !mc_res_stall.
  - Simultaneous grant and response: no change.
  - Saturates at 0; a stray response after reset is routed but not counted.
- Response routing (combinational, zero latency):
  - id = mc_res_rtnctl[31:32-IDW].
  - res_valid = mc_res_valid << id.
  - res_rtnctl = mc_res_rtnctl[RTW-1:0].
  - mc_res_stall = res_stall[id].
  - id ≥ NREQ: response consumed and dropped, res_valid = 0.
- Flush FSM:
  - IDLE: when |flush_req, latch mask = flush_req, go to DRAIN. Grants are blocked from this cycle onward.
  - DRAIN: OR new flush_req bits into mask. When mc_req_valid==0 and outstanding==0, go to FLUSH.
  - FLUSH: hold mc_req_flush = 1 until mc_res_flush_ok == 1, then go to DONE.
  - DONE: flush_ok = mask for one cycle; clear mask; go to IDLE.
  - A flush_req still held high in IDLE starts a new flush. Requesters must drop flush_req on flush_ok.
- Reset mid-flush: FSM returns to IDLE, mc_req_flush drops, and the mask is lost.

Optional Feature:
- Macro: WOLV_MC_ARB_PERF_EN.
- Defined: adds two ports.
  - perf_sel in clog2(NREQ)+1: selects a counter.
  - perf_data out 32: selected value, registered with 1-cycle latency.
  - Selection 0..NREQ-1: per-requester grant counters.
  - Selection NREQ: count of cycles with mc_req_stall=1 and some req_valid.
  - All counters are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: ports and counters are absent; functionality is otherwise identical.

Decomposition:
- Package wolverine_mc_pkg:
  - Widths: MC_ADDR_W=48, MC_DATA_W=64, MC_RTNCTL_W=32, MC_SIZE_W=2, MC_CMD_W=3, MC_SCMD_W=4.
  - Command encodings: RD, WR, plus the others used.
  - Enum flush_state_t {IDLE, DRAIN, FLUSH, DONE}.
- Sub-module wolverine_rr_arbiter: NREQ-wide round-robin pick, with enable and pointer update.

Test Plan:
- Single requester 0 issues 4 back-to-back reads, rtnctl=5 → mc_req_valid high 4 consecutive cycles starting 1 cycle after the first grant, mc_req_rtnctl=0x00000005.
- All 4 requesters valid continuously for 8 grants → grant order 0,1,2,3,0,1,2,3; requester 2 beats carry rtnctl[31:30]=2.
- mc_req_stall high for 10 cycles while requesters are valid → exactly one registered beat leaves after stall rises, then none; issue resumes the cycle after stall drops.
- Responses with rtnctl=0xC0000007 and 0x40000001 → res_valid=4'b1000 with res_rtnctl=7, then 4'b0010 with res_rtnctl=1. res_stall[3]=1 → mc_res_stall=1 and the counter holds.
- MAXOUT=64 reached with no responses → no grants. One response → exactly one more grant.
- flush_req[1] with 3 outstanding → mc_req_flush asserted only after the 3rd response. Downstream flush_ok after 5 cycles → flush_ok=4'b0010 for one cycle, no grants during DRAIN/FLUSH/DONE. Repeat with reset_n=0 mid-FLUSH → outputs return to reset values.
